// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples cs/sck/mosi in the clk domain, delivers received
// bytes on a strobe and shifts out bytes taken from a one-deep transmit holding register.
module spi_slave #(
    parameter int                DATA_N = 8,
    parameter logic [DATA_N-1:0] DUMMY  = 8'hFF
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              cs,
    input  logic              sck,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_N-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_N-1:0] rx_data,
    output logic              rx_valid,
    output logic              underrun
);

    localparam int             CNT_W    = (DATA_N > 2) ? $clog2(DATA_N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_N - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t            state_r, state_nxt_s;
    logic              cs_meta_r, cs_sync_r, cs_prev_r;
    logic              sck_meta_r, sck_sync_r, sck_prev_r;
    logic              mosi_meta_r, mosi_sync_r;
    logic [1:0]        fill_r;
    logic              armed_r;
    logic              cs_fall_s, cs_rise_s, sck_rise_s, sck_fall_s;
    logic              load_s, shift_s, upd_s, abort_s, hs_s;
    logic [DATA_N-1:0] shift_r, shift_nxt_s, tx_byte_s, hold_r, rx_data_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              pend_r, full_r, miso_r, miso_oe_r, rx_valid_r, underrun_r;

    // Input synchronizers, edge history and post-reset arming of cs fall detection
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
            cs_prev_r   <= 1'b1;
            sck_meta_r  <= 1'b0;
            sck_sync_r  <= 1'b0;
            sck_prev_r  <= 1'b0;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
            fill_r      <= 2'b00;
            armed_r     <= 1'b0;
        end else begin
            cs_meta_r   <= cs;
            cs_sync_r   <= cs_meta_r;
            cs_prev_r   <= cs_sync_r;
            sck_meta_r  <= sck;
            sck_sync_r  <= sck_meta_r;
            sck_prev_r  <= sck_sync_r;
            mosi_meta_r <= mosi;
            mosi_sync_r <= mosi_meta_r;
            fill_r      <= {fill_r[0], 1'b1};
            // A cs already low at reset release must be seen high before a fall counts
            armed_r     <= armed_r | (fill_r[1] & cs_sync_r);
        end
    end

    assign cs_fall_s   = armed_r & cs_prev_r & ~cs_sync_r;
    assign cs_rise_s   = ~cs_prev_r & cs_sync_r;
    assign sck_rise_s  = ~sck_prev_r & sck_sync_r;
    assign sck_fall_s  = sck_prev_r & ~sck_sync_r;
    assign shift_nxt_s = {shift_r[DATA_N-2:0], mosi_sync_r};
    assign tx_byte_s   = full_r ? hold_r : DUMMY;
    assign hs_s        = tx_valid & ~full_r;

    // State register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    if (cs_fall_s) state_nxt_s = ACTIVE; else state_nxt_s = IDLE;
            ACTIVE:  if (cs_rise_s) state_nxt_s = IDLE;   else state_nxt_s = ACTIVE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Per-cycle datapath actions; cs rise wins over a coincident sck edge
    always_comb begin
        load_s  = 1'b0;
        shift_s = 1'b0;
        upd_s   = 1'b0;
        abort_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (cs_fall_s) load_s = 1'b1; else load_s = 1'b0;
            end
            ACTIVE: begin
                if (cs_rise_s)                 abort_s = 1'b1;
                else if (sck_rise_s)           shift_s = 1'b1;
                else if (sck_fall_s && pend_r) load_s  = 1'b1;
                else if (sck_fall_s)           upd_s   = 1'b1;
                else                           abort_s = 1'b0;
            end
            default: abort_s = 1'b0;
        endcase
    end

    // Shift register, bit counter and registered serial/strobe outputs
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            shift_r    <= {DATA_N{1'b0}};
            rx_data_r  <= {DATA_N{1'b0}};
            cnt_r      <= CNT_ZERO;
            pend_r     <= 1'b0;
            miso_r     <= 1'b1;
            miso_oe_r  <= 1'b0;
            rx_valid_r <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            underrun_r <= 1'b0;
            miso_oe_r  <= (state_nxt_s == ACTIVE);
            if (load_s) begin
                shift_r    <= tx_byte_s;
                miso_r     <= tx_byte_s[DATA_N-1];
                underrun_r <= ~full_r;
                cnt_r      <= CNT_ZERO;
                pend_r     <= 1'b0;
            end else if (shift_s) begin
                shift_r <= shift_nxt_s;
                if (cnt_r == CNT_LAST) begin
                    cnt_r      <= CNT_ZERO;
                    rx_data_r  <= shift_nxt_s;
                    rx_valid_r <= 1'b1;
                    pend_r     <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end else if (upd_s) begin
                miso_r <= shift_r[DATA_N-1];
            end else if (abort_s) begin
                cnt_r  <= CNT_ZERO;
                pend_r <= 1'b0;
                miso_r <= 1'b1;
            end
        end
    end

    // Transmit holding register; a same-cycle load takes the old (empty) contents
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            hold_r <= {DATA_N{1'b0}};
            full_r <= 1'b0;
        end else if (hs_s) begin
            hold_r <= tx_data;
            full_r <= 1'b1;
        end else if (load_s) begin
            full_r <= 1'b0;
        end
    end

    assign miso     = miso_r;
    assign miso_oe  = miso_oe_r;
    assign tx_ready = ~full_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign underrun = underrun_r;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives an SPI mode-0 initiator with slow sck and
// checks serial data, strobes and holding-register handshake against fixed values.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       n_reset, cs, sck, mosi, tx_valid;
    logic [7:0] tx_data;
    logic       miso, miso_oe, tx_ready, rx_valid, underrun;
    logic [7:0] rx_data;

    int n_checks = 0;
    int n_fail   = 0;
    int rx_cnt   = 0;
    int ur_cnt   = 0;

    spi_slave #(.DATA_N(8), .DUMMY(8'hFF)) dut (
        .clk(clk), .n_reset(n_reset), .cs(cs), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // Strobe counters
    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_cnt <= rx_cnt + 1;
        if (underrun === 1'b1) ur_cnt <= ur_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic start_frame();
        cs = 1'b0;
        wait_clk(6);
    endtask

    task automatic end_frame();
        sck = 1'b0;
        cs  = 1'b1;
        wait_clk(8);
    endtask

    // Shifts nbits MSB first; when last is set the final bit leaves sck high for end_frame
    task automatic xfer(input logic [7:0] mo, input int nbits, input bit last, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = mo[i];
            wait_clk(4);
            mi[i] = miso;
            sck = 1'b1;
            wait_clk(8);
            if (!(last && i == 8 - nbits)) begin
                sck = 1'b0;
                wait_clk(4);
            end
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        wait_clk(3);
        repeat (4) begin
            cs = ~cs; sck = ~sck; mosi = ~mosi;
            wait_clk(3);
        end
        cs = 1'b1; sck = 1'b0;
        wait_clk(3);
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        n_checks++; if (miso !== 1'b1) begin n_fail++; $display("FAIL reset_miso: got %b expected 1", miso); end
        n_checks++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe: got %b expected 0", miso_oe); end
        n_checks++; if (rx_cnt + ur_cnt !== 0) begin n_fail++; $display("FAIL reset_strobes: got %0d expected 0", rx_cnt + ur_cnt); end
        n_reset = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_single_byte();
        logic [7:0] got;
        int rx0, ur0;
        rx0 = rx_cnt; ur0 = ur_cnt;
        load_tx(8'hA5);
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL single_tx_ready_full: got %b expected 0", tx_ready); end
        start_frame();
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL single_tx_ready_after_cs: got %b expected 1", tx_ready); end
        n_checks++; if (miso_oe !== 1'b1) begin n_fail++; $display("FAIL single_miso_oe: got %b expected 1", miso_oe); end
        xfer(8'h3C, 8, 1'b1, got);
        end_frame();
        n_checks++; if (got !== 8'hA5) begin n_fail++; $display("FAIL single_miso_bits: got %h expected a5", got); end
        n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL single_rx_data: got %h expected 3c", rx_data); end
        n_checks++; if (rx_cnt - rx0 !== 1) begin n_fail++; $display("FAIL single_rx_valid_count: got %0d expected 1", rx_cnt - rx0); end
        n_checks++; if (ur_cnt - ur0 !== 0) begin n_fail++; $display("FAIL single_underrun_count: got %0d expected 0", ur_cnt - ur0); end
        n_checks++; if (miso !== 1'b1) begin n_fail++; $display("FAIL single_miso_idle: got %b expected 1", miso); end
        n_checks++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL single_miso_oe_idle: got %b expected 0", miso_oe); end
    endtask

    task automatic test_empty_tx();
        logic [7:0] got;
        int rx0, ur0;
        rx0 = rx_cnt; ur0 = ur_cnt;
        start_frame();
        xfer(8'h5A, 8, 1'b1, got);
        end_frame();
        n_checks++; if (got !== 8'hFF) begin n_fail++; $display("FAIL empty_miso_bits: got %h expected ff", got); end
        n_checks++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL empty_rx_data: got %h expected 5a", rx_data); end
        n_checks++; if (rx_cnt - rx0 !== 1) begin n_fail++; $display("FAIL empty_rx_valid_count: got %0d expected 1", rx_cnt - rx0); end
        n_checks++; if (ur_cnt - ur0 !== 1) begin n_fail++; $display("FAIL empty_underrun_count: got %0d expected 1", ur_cnt - ur0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got1, got2;
        int rx0, ur0;
        rx0 = rx_cnt; ur0 = ur_cnt;
        load_tx(8'h12);
        cs = 1'b0;
        wait_clk(4);
        load_tx(8'h34);
        wait_clk(2);
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_tx_ready_held: got %b expected 0", tx_ready); end
        xfer(8'hC3, 8, 1'b0, got1);
        n_checks++; if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL b2b_rx_data_1: got %h expected c3", rx_data); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_tx_ready_reload: got %b expected 1", tx_ready); end
        xfer(8'h69, 8, 1'b1, got2);
        end_frame();
        n_checks++; if (got1 !== 8'h12) begin n_fail++; $display("FAIL b2b_miso_byte1: got %h expected 12", got1); end
        n_checks++; if (got2 !== 8'h34) begin n_fail++; $display("FAIL b2b_miso_byte2: got %h expected 34", got2); end
        n_checks++; if (rx_data !== 8'h69) begin n_fail++; $display("FAIL b2b_rx_data_2: got %h expected 69", rx_data); end
        n_checks++; if (rx_cnt - rx0 !== 2) begin n_fail++; $display("FAIL b2b_rx_valid_count: got %0d expected 2", rx_cnt - rx0); end
        n_checks++; if (ur_cnt - ur0 !== 0) begin n_fail++; $display("FAIL b2b_underrun_count: got %0d expected 0", ur_cnt - ur0); end
    endtask

    task automatic test_abort();
        logic [7:0] got;
        int rx0, ur0;
        rx0 = rx_cnt; ur0 = ur_cnt;
        start_frame();
        xfer(8'hE0, 3, 1'b0, got);
        cs = 1'b1;
        wait_clk(8);
        n_checks++; if (rx_cnt - rx0 !== 0) begin n_fail++; $display("FAIL abort_rx_valid_count: got %0d expected 0", rx_cnt - rx0); end
        n_checks++; if (ur_cnt - ur0 !== 1) begin n_fail++; $display("FAIL abort_underrun_count: got %0d expected 1", ur_cnt - ur0); end
        n_checks++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL abort_miso_oe: got %b expected 0", miso_oe); end
        n_checks++; if (miso !== 1'b1) begin n_fail++; $display("FAIL abort_miso_idle: got %b expected 1", miso); end
        rx0 = rx_cnt;
        start_frame();
        xfer(8'h81, 8, 1'b1, got);
        end_frame();
        n_checks++; if (rx_data !== 8'h81) begin n_fail++; $display("FAIL abort_next_rx_data: got %h expected 81", rx_data); end
        n_checks++; if (rx_cnt - rx0 !== 1) begin n_fail++; $display("FAIL abort_next_rx_count: got %0d expected 1", rx_cnt - rx0); end
        n_checks++; if (got !== 8'hFF) begin n_fail++; $display("FAIL abort_next_miso: got %h expected ff", got); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] got;
        int rx0, ur0;
        start_frame();
        load_tx(8'h77);
        xfer(8'hAA, 5, 1'b1, got);
        n_reset = 1'b0;
        wait_clk(2);
        n_checks++; if (miso !== 1'b1) begin n_fail++; $display("FAIL rstmid_miso: got %b expected 1", miso); end
        n_checks++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso_oe: got %b expected 0", miso_oe); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx_ready: got %b expected 1", tx_ready); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_rx_data: got %h expected 00", rx_data); end
        sck = 1'b0;
        wait_clk(2);
        n_reset = 1'b1;
        wait_clk(4);
        rx0 = rx_cnt; ur0 = ur_cnt;
        mosi = 1'b1;
        repeat (8) begin
            sck = 1'b1; wait_clk(8);
            sck = 1'b0; wait_clk(8);
        end
        n_checks++; if (rx_cnt - rx0 !== 0) begin n_fail++; $display("FAIL rstmid_no_rx: got %0d expected 0", rx_cnt - rx0); end
        n_checks++; if (ur_cnt - ur0 !== 0) begin n_fail++; $display("FAIL rstmid_no_underrun: got %0d expected 0", ur_cnt - ur0); end
        n_checks++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_not_selected: got %b expected 0", miso_oe); end
        cs = 1'b1;
        wait_clk(8);
        rx0 = rx_cnt; ur0 = ur_cnt;
        load_tx(8'hC6);
        start_frame();
        xfer(8'h5E, 8, 1'b1, got);
        end_frame();
        n_checks++; if (got !== 8'hC6) begin n_fail++; $display("FAIL rstmid_after_miso: got %h expected c6", got); end
        n_checks++; if (rx_data !== 8'h5E) begin n_fail++; $display("FAIL rstmid_after_rx_data: got %h expected 5e", rx_data); end
        n_checks++; if (rx_cnt - rx0 !== 1) begin n_fail++; $display("FAIL rstmid_after_rx_count: got %0d expected 1", rx_cnt - rx0); end
        n_checks++; if (ur_cnt - ur0 !== 0) begin n_fail++; $display("FAIL rstmid_after_underrun: got %0d expected 0", ur_cnt - ur0); end
    endtask

    // First-bit miso appears on the third clk edge after the raw cs fall
    task automatic test_latency();
        load_tx(8'h00);
        cs = 1'b0;
        wait_clk(2);
        n_checks++; if (miso !== 1'b1) begin n_fail++; $display("FAIL lat_miso_early: got %b expected 1", miso); end
        n_checks++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL lat_oe_early: got %b expected 0", miso_oe); end
        wait_clk(1);
        n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL lat_miso_edge3: got %b expected 0", miso); end
        n_checks++; if (miso_oe !== 1'b1) begin n_fail++; $display("FAIL lat_oe_edge3: got %b expected 1", miso_oe); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL lat_tx_ready_edge3: got %b expected 1", tx_ready); end
        cs = 1'b1;
        wait_clk(8);
        n_checks++; if (miso !== 1'b1) begin n_fail++; $display("FAIL lat_miso_release: got %b expected 1", miso); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_empty_tx();
        test_back_to_back();
        test_abort();
        test_reset_mid_frame();
        test_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
